// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter that shares one UART transmitter among NUM_REQ byte streams.
// An owner keeps the transmitter until its last byte completes or it stalls past TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 1_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  input  logic                 tx_done,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StWait} state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IdxW-1:0]     owner_q, owner_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic                last_q, last_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                tx_start_q, tx_start_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic                timeout_err_q, timeout_err_d;
  logic                busy_q, busy_d;

  logic                owner_valid, owner_last;
  logic [7:0]          owner_byte;
  logic                pick_found;
  logic [IdxW-1:0]     pick_idx, cand;

  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_byte  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IdxW'(i)) begin
        owner_valid = req_valid[i];
        owner_last  = req_last[i];
        owner_byte  = req_data[8*i +: 8];
      end
    end
  end

  // Search starts just after the last owner and wraps, so each requester waits at most one round.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IdxW'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    tx_start_d    = 1'b0;
    tx_data_d     = tx_data_q;
    req_ready_d   = '0;
    timeout_err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d = NUM_REQ'(1) << pick_idx;
          owner_d = pick_idx;
          cnt_d   = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (owner_valid && !tx_busy) begin
          tx_start_d  = 1'b1;
          tx_data_d   = owner_byte;
          req_ready_d = grant_q;
          last_d      = owner_last;
          cnt_d       = '0;
          state_d     = StWait;
        end else if (!owner_valid) begin
          if (cnt_q == CntLast) begin
            timeout_err_d = 1'b1;
            rr_ptr_d      = owner_q;
            grant_d       = '0;
            state_d       = StIdle;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StWait: begin
        if (tx_done) begin
          if (last_q) begin
            rr_ptr_d = owner_q;
            grant_d  = '0;
            state_d  = StIdle;
          end else begin
            state_d = StLoad;
          end
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase

    busy_d = |grant_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      grant_q       <= '0;
      owner_q       <= '0;
      rr_ptr_q      <= IdxW'(NUM_REQ - 1);
      last_q        <= 1'b0;
      cnt_q         <= '0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= 8'h00;
      req_ready_q   <= '0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      req_ready_q   <= req_ready_d;
      timeout_err_q <= timeout_err_d;
      busy_q        <= busy_d;
    end
  end

  assign grant       = grant_q;
  assign req_ready   = req_ready_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule
